banked_ram: RTL

//  Parametrised multi-bank word RAM: NUM_BANKS banks of BANK_DEPTH x DATA_WIDTH behind one

---
 rtl/banked_ram.sv | 116 +++++++++++
 1 files changed

// File: rtl/banked_ram.sv
// rtl/banked_ram.sv - multi-bank byte-writable word RAM with zero-fill sequencer
// One request port fans out to NUM_BANKS banks; read data returns one cycle later.
module banked_ram #(
  parameter  int NUM_BANKS  = 4,
  parameter  int BANK_DEPTH = 512,
  parameter  int DATA_WIDTH = 32,
  localparam int BANK_BITS  = $clog2(NUM_BANKS),
  localparam int ROW_BITS   = $clog2(BANK_DEPTH),
  localparam int ADDR_WIDTH = BANK_BITS + ROW_BITS,
  localparam int NUM_LANES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NUM_LANES-1:0]  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q;
  logic [ROW_BITS-1:0]   fill_cnt_q;
  logic                  req_ready_q;
  logic                  init_done_q;
  logic                  rsp_valid_q;
  logic [BANK_BITS-1:0]  rsp_bank_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  logic                  in_init;
  logic                  accept;
  logic [BANK_BITS-1:0]  acc_bank;
  logic [ROW_BITS-1:0]   mem_row;
  logic [NUM_LANES-1:0]  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_BANKS-1:0]  bank_en;
  logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];

  // The fill sequencer borrows the same write path as normal requests, on all banks at once.
  always_comb begin
    in_init   = (state_q == S_INIT) && !rst;
    accept    = (state_q == S_RUN) && req_valid && req_ready_q && !rst;
    acc_bank  = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
    mem_row   = in_init ? fill_cnt_q : req_addr[ROW_BITS-1:0];
    mem_we    = in_init ? {NUM_LANES{1'b1}} : req_we;
    mem_wdata = in_init ? '0 : req_wdata;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en[b] = in_init || (accept && (acc_bank == BANK_BITS'(b)));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (bank_en[b]) begin
        if (|mem_we) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (mem_we[l]) mem[mem_row][8*l +: 8] <= mem_wdata[8*l +: 8];
          end
        end else begin
          dout_q <= mem[mem_row];
        end
      end
    end

    assign bank_dout[b] = dout_q;
  end

  // Mux by the bank captured at acceptance, so a new req_addr cannot disturb a pending response.
  always_comb begin
    rsp_rdata_d = rsp_valid_q ? bank_dout[rsp_bank_q] : rsp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      fill_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bank_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_rdata_q <= rsp_rdata_d;
      case (state_q)
        S_INIT: begin
          rsp_valid_q <= 1'b0;
          fill_cnt_q  <= fill_cnt_q + 1'b1;
          if (fill_cnt_q == ROW_BITS'(BANK_DEPTH - 1)) begin
            state_q     <= S_RUN;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          rsp_valid_q <= accept && (req_we == '0);
          if (accept) rsp_bank_q <= acc_bank;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_d;

endmodule
